// File: rtl/pomdp_pkg.sv
// Shared types, constants and helpers for the POMDP simulation controller.
package pomdp_pkg;

  localparam int unsigned ELEM_W      = 16;
  localparam int unsigned NUM_STATES  = 2;
  localparam int unsigned NUM_ACTIONS = 3;
  localparam int unsigned ACT_W       = 2;
  localparam int unsigned BELIEF_W    = NUM_STATES * ELEM_W;
  localparam int unsigned RTAB_W      = NUM_ACTIONS * NUM_STATES * ELEM_W;

  // Action code one past the last legal action marks a bad decision.
  localparam logic [ACT_W-1:0] ACT_INVALID = ACT_W'(NUM_ACTIONS);

  typedef logic signed [ELEM_W-1:0] reward_t;
  typedef logic        [ELEM_W-1:0] belief_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECIDE,
    S_STATE,
    S_OBS,
    S_BELIEF,
    S_ACCUM,
    S_FINISH
  } state_e;

  // Pick reward[act][st] from the flattened table; entry act*NUM_STATES+st is at that element slot.
  function automatic reward_t reward_sel(input logic [RTAB_W-1:0] tab,
                                         input logic [ACT_W-1:0]  act,
                                         input logic              st);
    reward_t r;
    r = '0;
    case ({act, st})
      3'd0:    r = tab[0*ELEM_W +: ELEM_W];
      3'd1:    r = tab[1*ELEM_W +: ELEM_W];
      3'd2:    r = tab[2*ELEM_W +: ELEM_W];
      3'd3:    r = tab[3*ELEM_W +: ELEM_W];
      3'd4:    r = tab[4*ELEM_W +: ELEM_W];
      3'd5:    r = tab[5*ELEM_W +: ELEM_W];
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sat_acc.sv
// Signed accumulator that clamps at the signed ACC_W limits instead of wrapping.
module sat_acc #(
  parameter int unsigned ACC_W = 32,
  parameter int unsigned IN_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [IN_W-1:0]  din,
  output logic signed [ACC_W-1:0] acc
);

  localparam int unsigned EXT_W = ACC_W + 1;

  logic [EXT_W-1:0] sum_c;
  logic [ACC_W-1:0] sat_c;

  // One guard bit exposes overflow as a disagreement between the top two sum bits.
  always_comb begin
    sum_c = {acc[ACC_W-1], acc} + {{(EXT_W-IN_W){din[IN_W-1]}}, din};
    sat_c = sum_c[ACC_W-1:0];
    if (sum_c[ACC_W] != sum_c[ACC_W-1]) begin
      sat_c = sum_c[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // Accumulator register; clear wins over accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sat_c;
    end
  end

endmodule

// File: rtl/pomdp_sim_ctrl.sv
// Sequences decide/state/observe/belief handshakes per simulation step and accumulates reward.
module pomdp_sim_ctrl
  import pomdp_pkg::*;
#(
  parameter int unsigned STEP_W  = 16,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [STEP_W-1:0]       num_steps,
  input  logic                    init_state,
  input  logic [BELIEF_W-1:0]     init_belief,
  input  logic [RTAB_W-1:0]       reward_tab,
  output logic                    dec_en,
  input  logic                    dec_done,
  input  logic [ACT_W-1:0]        dec_action,
  output logic                    st_en,
  input  logic                    st_done,
  input  logic                    st_new_state,
  output logic                    obs_en,
  input  logic                    obs_done,
  input  logic                    obs_value,
  output logic                    bel_en,
  input  logic                    bel_done,
  input  logic [BELIEF_W-1:0]     bel_renew,
  output logic                    cur_state,
  output logic [BELIEF_W-1:0]     cur_belief,
  output logic [ACT_W-1:0]        cur_action,
  output logic [STEP_W-1:0]       step_cnt,
  output logic signed [ACC_W-1:0] reward_acc,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int unsigned WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_e            state;
  state_e            state_n;
  logic [WD_W-1:0]   wd_cnt;
  reward_t           rew_hold;
  logic              obs_lat;
  logic              waiting_c;
  logic              wd_expired_c;
  logic              start_ok_c;
  logic              error_set_c;
  logic              acc_en_c;
  logic [STEP_W-1:0] step_nxt_c;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; watchdog expiry overrides a wait that saw no done.
  always_comb begin
    state_n      = state;
    start_ok_c   = 1'b0;
    error_set_c  = 1'b0;
    acc_en_c     = 1'b0;
    waiting_c    = state inside {S_DECIDE, S_STATE, S_OBS, S_BELIEF};
    wd_expired_c = waiting_c && (wd_cnt == WD_W'(TIMEOUT - 1));
    step_nxt_c   = step_cnt + STEP_W'(1);
    case (state)
      S_IDLE: begin
        if (start) begin
          start_ok_c = 1'b1;
          state_n    = (num_steps != '0) ? S_DECIDE : S_FINISH;
        end
      end
      S_DECIDE: begin
        if (dec_done) begin
          if (dec_action == ACT_INVALID) begin
            error_set_c = 1'b1;
            state_n     = S_FINISH;
          end else begin
            state_n = S_STATE;
          end
        end
      end
      S_STATE:  if (st_done)  state_n = S_OBS;
      S_OBS:    if (obs_done) state_n = S_BELIEF;
      S_BELIEF: if (bel_done) state_n = S_ACCUM;
      S_ACCUM: begin
        acc_en_c = 1'b1;
        state_n  = (step_nxt_c < num_steps) ? S_DECIDE : S_FINISH;
      end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    if (wd_expired_c && (state_n == state)) begin
      error_set_c = 1'b1;
      state_n     = S_FINISH;
    end
  end

  // Registered handshake strobes, status flags, watchdog and per-step datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_en     <= 1'b0;
      st_en      <= 1'b0;
      obs_en     <= 1'b0;
      bel_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      wd_cnt     <= '0;
      cur_state  <= 1'b0;
      cur_belief <= '0;
      cur_action <= '0;
      step_cnt   <= '0;
      rew_hold   <= '0;
      obs_lat    <= 1'b0;
    end else begin
      dec_en <= (state_n == S_DECIDE) && (state != S_DECIDE);
      st_en  <= (state_n == S_STATE)  && (state != S_STATE);
      obs_en <= (state_n == S_OBS)    && (state != S_OBS);
      bel_en <= (state_n == S_BELIEF) && (state != S_BELIEF);
      busy   <= (state_n != S_IDLE);
      done   <= (state_n == S_FINISH);

      if ((state_n != state) || !waiting_c) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end

      if (start_ok_c) begin
        cur_state  <= init_state;
        cur_belief <= init_belief;
        step_cnt   <= '0;
        error      <= 1'b0;
      end else if (error_set_c) begin
        error <= 1'b1;
      end

      if (state == S_DECIDE && dec_done) begin
        cur_action <= dec_action;
      end
      if (state == S_STATE && st_done) begin
        rew_hold  <= reward_sel(reward_tab, cur_action, cur_state);
        cur_state <= st_new_state;
      end
      obs_lat <= (state == S_OBS && obs_done) ? obs_value : obs_lat;
      if (state == S_BELIEF && bel_done) begin
        cur_belief <= bel_renew;
      end
      if (state == S_ACCUM) begin
        step_cnt <= step_nxt_c;
      end
    end
  end

  sat_acc #(
    .ACC_W (ACC_W),
    .IN_W  (ELEM_W)
  ) u_sat_acc (
    .clk (clk),
    .rst (rst),
    .clr (start_ok_c),
    .en  (acc_en_c),
    .din (rew_hold),
    .acc (reward_acc)
  );

endmodule
